// File: rtl/util_clk_recover_pkg.sv
// Shared types and edge-selection helper for the serial clock recovery block.
package util_clk_recover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Map detected sclk edges onto {shift, latch} for the given CPOL/CPHA mode.
    function automatic logic [1:0] strobe_sel(input logic cpol, input logic cpha,
                                              input logic rise, input logic fall);
        logic leading;
        logic trailing;
        leading  = cpol ? fall : rise;
        trailing = cpol ? rise : fall;
        return cpha ? {leading, trailing} : {trailing, leading};
    endfunction

endpackage

// File: rtl/util_clk_recover_sync.sv
// Multi-flop synchronizer for a single asynchronous control bit.
module util_sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= {STAGES{RST_VAL}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/util_clk_recover.sv
// Slave-side serial clock recovery: synchronizes sclk/cs_n from a remote master and
// produces single-cycle shift/latch strobes plus frame status in the clk domain.
module util_clk_recover
    import util_clk_recover_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [CNT_WIDTH-1:0] bit_len,
    input  logic                 sclk_in,
    input  logic                 cs_n_in,
    output logic                 shift_en,
    output logic                 latch_en,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] bit_cnt,
    output logic                 busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state, state_nxt;
    logic                 sclk_s, sclk_d, cs_n_s;
    logic                 rise, fall, edge_any, shift_sel, latch_sel;
    logic [CNT_WIDTH-1:0] len_q, len_nxt, bit_cnt_nxt;
    logic [TO_W-1:0]      tcnt, tcnt_nxt;
    logic                 hold_q, hold_nxt;
    logic                 shift_nxt, latch_nxt, start_nxt, done_nxt, abort_nxt, timeout_nxt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] norm_len(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? CNT_WIDTH'(1) : v;
    endfunction

    util_sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk_in), .q(sclk_s)
    );

    util_sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n_in), .q(cs_n_s)
    );

    assign rise     = sclk_s & ~sclk_d;
    assign fall     = ~sclk_s & sclk_d;
    assign edge_any = rise | fall;
    assign {shift_sel, latch_sel} = strobe_sel(cpol, cpha, rise, fall);
    assign busy     = (state != ST_IDLE);

    // State, frame length, idle-timer and previous-sclk registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            len_q  <= CNT_WIDTH'(1);
            tcnt   <= '0;
            hold_q <= 1'b0;
            sclk_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            len_q  <= len_nxt;
            tcnt   <= tcnt_nxt;
            hold_q <= hold_nxt;
            sclk_d <= sclk_s;
        end
    end

    // Next-state decode; the last latch of a frame takes priority over cs_n release.
    // After a timeout the frame is stale, so a new frame waits for cs_n to be released.
    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        tcnt_nxt    = tcnt;
        hold_nxt    = hold_q & ~cs_n_s;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = 1'b0;
        latch_nxt   = 1'b0;
        start_nxt   = 1'b0;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && !cs_n_s && !hold_q) begin
                    state_nxt   = ST_ACTIVE;
                    start_nxt   = 1'b1;
                    bit_cnt_nxt = '0;
                    len_nxt     = norm_len(bit_len);
                    tcnt_nxt    = '0;
                end
            end
            ST_ACTIVE: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (latch_sel && (bit_cnt == len_q - CNT_WIDTH'(1))) begin
                    latch_nxt   = 1'b1;
                    done_nxt    = 1'b1;
                    bit_cnt_nxt = sat_inc(bit_cnt);
                    state_nxt   = ST_DONE;
                end else if (cs_n_s) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (edge_any) begin
                    tcnt_nxt  = '0;
                    shift_nxt = shift_sel;
                    latch_nxt = latch_sel;
                    if (latch_sel) bit_cnt_nxt = sat_inc(bit_cnt);
                end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_nxt = 1'b1;
                    hold_nxt    = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end
            ST_DONE: begin
                if (!en || cs_n_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered strobes and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_en    <= 1'b0;
            latch_en    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            timeout_err <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            shift_en    <= shift_nxt;
            latch_en    <= latch_nxt;
            frame_start <= start_nxt;
            frame_done  <= done_nxt;
            frame_abort <= abort_nxt;
            timeout_err <= timeout_nxt;
            bit_cnt     <= bit_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_util_clk_recover.sv
// Directed bench for util_clk_recover: CPOL/CPHA mapping, latency, abort, timeout, reset.
module tb_util_clk_recover;

    logic       clk = 1'b0;
    logic       rst, en, cpol, cpha, sclk_in, cs_n_in;
    logic [7:0] bit_len;
    logic       shift_en, latch_en, frame_start, frame_done, frame_abort, timeout_err, busy;
    logic [7:0] bit_cnt;

    int errors = 0;
    int checks = 0;
    int n_shift = 0, n_latch = 0, n_start = 0, n_done = 0, n_abort = 0, n_to = 0;
    int s_shift, s_latch, s_start, s_done, s_abort, s_to;

    always #5 clk = ~clk;

    util_clk_recover #(.SYNC_STAGES(2), .CNT_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .en(en), .cpol(cpol), .cpha(cpha), .bit_len(bit_len),
        .sclk_in(sclk_in), .cs_n_in(cs_n_in), .shift_en(shift_en), .latch_en(latch_en),
        .frame_start(frame_start), .frame_done(frame_done), .frame_abort(frame_abort),
        .timeout_err(timeout_err), .bit_cnt(bit_cnt), .busy(busy)
    );

    // Pulse counters, sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (shift_en)    n_shift++;
        if (latch_en)    n_latch++;
        if (frame_start) n_start++;
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
        if (timeout_err) n_to++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_shift = n_shift; s_latch = n_latch; s_start = n_start;
        s_done  = n_done;  s_abort = n_abort; s_to    = n_to;
    endtask

    // Drive one sclk edge, then expect nothing for 2 cycles and the strobes on the 3rd.
    task automatic edge_check(input logic lvl, input logic s, input logic l, input logic d,
                              input string tag);
        sclk_in = lvl;
        @(posedge clk); @(negedge clk);
        check({tag, "/lat1"}, {shift_en, latch_en}, 2'b00);
        @(posedge clk); @(negedge clk);
        check({tag, "/lat2"}, {shift_en, latch_en}, 2'b00);
        @(posedge clk); @(negedge clk);
        check({tag, "/shift"}, shift_en, s);
        check({tag, "/latch"}, latch_en, l);
        check({tag, "/done"}, frame_done, d);
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input string tag);
        cs_n_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "/start"}, frame_start, 1'b1);
        check({tag, "/busy"}, busy, 1'b1);
        check({tag, "/cnt0"}, bit_cnt, 8'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic pol, input logic pha, input logic [7:0] len_in,
                             input int nbits, input int extra, input string tag);
        cpol = pol; cpha = pha; bit_len = len_in;
        if (sclk_in !== pol) begin
            sclk_in = pol;
            tick(6);
        end else begin
            tick(4);
        end
        start_frame(tag);
        for (int b = 0; b < nbits; b++) begin
            edge_check(~pol, pha, ~pha, ~pha && (b == nbits - 1), {tag, "/lead"});
            edge_check(pol, ~pha && (b != nbits - 1), pha, pha && (b == nbits - 1),
                       {tag, "/trail"});
        end
        for (int e = 0; e < extra; e++) begin
            edge_check(~pol, 1'b0, 1'b0, 1'b0, {tag, "/xlead"});
            edge_check(pol, 1'b0, 1'b0, 1'b0, {tag, "/xtrail"});
        end
        check({tag, "/cnt"}, bit_cnt, nbits);
        check({tag, "/busy_done"}, busy, 1'b1);
        cs_n_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "/idle"}, busy, 1'b0);
        check({tag, "/hold"}, bit_cnt, nbits);
        check({tag, "/noabort"}, frame_abort, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cpol = 1'b0; cpha = 1'b0; bit_len = 8'd8;
        sclk_in = 1'b0; cs_n_in = 1'b1;
        tick(3);
        check("rst/strobes", {shift_en, latch_en, frame_start, frame_done, frame_abort,
                              timeout_err}, 6'd0);
        check("rst/bit_cnt", bit_cnt, 8'd0);
        check("rst/busy", busy, 1'b0);
        rst = 1'b0; en = 1'b1;
        tick(4);

        // Mode 0, 8 bits
        snap();
        run_frame(1'b0, 1'b0, 8'd8, 8, 0, "m0len8");
        check("m0len8/n_latch", n_latch - s_latch, 8);
        check("m0len8/n_shift", n_shift - s_shift, 7);
        check("m0len8/n_start", n_start - s_start, 1);
        check("m0len8/n_done", n_done - s_done, 1);

        // All four modes, 4 bits
        snap();
        run_frame(1'b0, 1'b0, 8'd4, 4, 0, "mode00");
        run_frame(1'b0, 1'b1, 8'd4, 4, 0, "mode01");
        run_frame(1'b1, 1'b0, 8'd4, 4, 0, "mode10");
        run_frame(1'b1, 1'b1, 8'd4, 4, 0, "mode11");
        check("modes/n_latch", n_latch - s_latch, 16);
        check("modes/n_shift", n_shift - s_shift, 14);
        check("modes/n_done", n_done - s_done, 4);

        // Abort after 3 latches
        cpol = 1'b0; cpha = 1'b0; bit_len = 8'd8; sclk_in = 1'b0;
        tick(6);
        snap();
        start_frame("abort");
        for (int b = 0; b < 3; b++) begin
            edge_check(1'b1, 1'b0, 1'b1, 1'b0, "abort/rise");
            edge_check(1'b0, 1'b1, 1'b0, 1'b0, "abort/fall");
        end
        cs_n_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort/pulse", frame_abort, 1'b1);
        check("abort/busy", busy, 1'b0);
        check("abort/cnt", bit_cnt, 8'd3);
        @(posedge clk); @(negedge clk);
        check("abort/one_cycle", frame_abort, 1'b0);
        @(posedge clk); #1;
        check("abort/n_done", n_done - s_done, 0);
        check("abort/n_abort", n_abort - s_abort, 1);

        // Timeout after 2 bits, then edges with cs_n still low
        tick(4);
        snap();
        start_frame("tmo");
        for (int b = 0; b < 2; b++) begin
            edge_check(1'b1, 1'b0, 1'b1, 1'b0, "tmo/rise");
            edge_check(1'b0, 1'b1, 1'b0, 1'b0, "tmo/fall");
        end
        repeat (62) @(posedge clk);
        @(negedge clk);
        check("tmo/early", timeout_err, 1'b0);
        @(posedge clk); @(negedge clk);
        check("tmo/pulse", timeout_err, 1'b1);
        check("tmo/busy", busy, 1'b0);
        check("tmo/cnt", bit_cnt, 8'd2);
        @(posedge clk); @(negedge clk);
        check("tmo/one_cycle", timeout_err, 1'b0);
        @(posedge clk); #1;
        for (int e = 0; e < 5; e++)
            edge_check(~sclk_in, 1'b0, 1'b0, 1'b0, "tmo/after");
        check("tmo/n_start", n_start - s_start, 1);
        check("tmo/n_latch", n_latch - s_latch, 2);
        check("tmo/n_to", n_to - s_to, 1);
        check("tmo/n_abort", n_abort - s_abort, 0);
        sclk_in = 1'b0; cs_n_in = 1'b1;
        tick(6);

        // bit_len = 0 behaves as 1; extra edges in DONE are ignored
        snap();
        run_frame(1'b0, 1'b0, 8'd0, 1, 3, "len0");
        check("len0/n_latch", n_latch - s_latch, 1);
        check("len0/n_done", n_done - s_done, 1);
        check("len0/n_shift", n_shift - s_shift, 0);

        // Asynchronous reset mid-frame
        bit_len = 8'd8;
        tick(4);
        snap();
        start_frame("arst");
        edge_check(1'b1, 1'b0, 1'b1, 1'b0, "arst/rise");
        edge_check(1'b0, 1'b1, 1'b0, 1'b0, "arst/fall");
        sclk_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst/pre_latch", latch_en, 1'b1);
        check("arst/pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("arst/latch", latch_en, 1'b0);
        check("arst/busy", busy, 1'b0);
        check("arst/cnt", bit_cnt, 8'd0);
        check("arst/flags", {frame_start, frame_done, frame_abort, timeout_err}, 4'd0);
        sclk_in = 1'b0; cs_n_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(4);
        check("arst/n_abort", n_abort - s_abort, 0);

        // Back-to-back frames
        snap();
        run_frame(1'b0, 1'b1, 8'd4, 4, 0, "b2b_a");
        run_frame(1'b0, 1'b1, 8'd4, 4, 0, "b2b_b");
        check("b2b/n_start", n_start - s_start, 2);
        check("b2b/n_done", n_done - s_done, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
